updown_counter_param: RTL and testbench
=======================================

# updown_counter_param

Parametrised up/down event counter that generalises the project's 16-bit inc/up-down counter. Adds programmable step, programmable lower/upper limits, wrap or saturate mode, synchronous load and clear, terminal-count flags and a sticky overflow indicator. Sits between debounced switch/pulse logic and display or control consumers. One instance per counted quantity.

## Interface
- WIDTH, 16, counter and limit width (2..32)
- STEP_W, 4, width of step input
- SATURATE, 0, 0 = wrap at limits, 1 = clip at limits
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of q to lo_lim
- ld  in  1  synchronous load of ld_val
- ld_val  in  WIDTH  load value
- inc  in  1  count enable, one step per cycle while high
- uphdnl  in  1  direction: 1 = up, 0 = down
- step  in  STEP_W  increment magnitude, unsigned
- lo_lim  in  WIDTH  lower bound, inclusive
- hi_lim  in  WIDTH  upper bound, inclusive
- ovf_clr  in  1  clears ovf_sticky
- q  out  WIDTH  count, registered
- wrap  out  1  registered one-cycle pulse, limit crossed on previous edge
- ovf_sticky  out  1  registered, set on any wrap or clip
- at_max  out  1  combinational, q == hi_lim
- at_min  out  1  combinational, q == lo_lim
- cfg_err  out  1  combinational, lo_lim > hi_lim

## Operation
- Reset (async, active-high): q = 0, wrap = 0, ovf_sticky = 0. Reset value ignores lo_lim.
- Per-edge priority: clr > ld > inc > hold.
- clr: q <= lo_lim. No wrap pulse. ovf_sticky unchanged.
- ld: q <= ld_val clamped to [lo_lim, hi_lim]. Clamping does not pulse wrap or set ovf_sticky.
- inc with cfg_err = 1, or with step = 0: q holds, no pulse.
- inc up: compute s = q + step in WIDTH+1 bits.
  - If s <= hi_lim: q <= s.
  - Otherwise, with SATURATE=0: q <= lo_lim, wrap pulses. The reload is not modular and the remainder is discarded.
  - Otherwise, with SATURATE=1: q <= hi_lim, wrap stays 0, ovf_sticky sets.
  - If already at hi_lim in saturate mode, ovf_sticky still sets on every inc.
- inc down: compute d = q - step in WIDTH+1 bits, signed.
  - If d >= lo_lim: q <= d.
  - Otherwise, with SATURATE=0: q <= hi_lim, wrap pulses.
  - Otherwise, with SATURATE=1: q <= lo_lim, ovf_sticky sets.
- q outside [lo_lim, hi_lim] (after reset or a limit change) with inc: q <= nearest limit (hi_lim if above, lo_lim if below). No wrap, no ovf. Direction is ignored for that cycle.
- ovf_sticky: set by any wrap pulse or clip. Cleared by ovf_clr. A set and a clear in the same cycle leaves it set.
- Limit arithmetic never overflows WIDTH: the up compare uses the carry bit and the down compare uses the borrow bit.

## Timing
- All state changes occur on the rising clk edge, except the async reset assert.
- Latency from inc/ld/clr to q: 1 cycle.
- wrap is high for exactly the cycle following the wrapping edge, concurrent with the reloaded q.
- Consecutive wrapping incs give consecutive wrap-high cycles.
- at_max, at_min and cfg_err follow q and the limits combinationally, with 0 cycle latency.
- inputs may change every cycle; step, direction and limits are sampled on the same edge as inc.
- Reset asserted mid-count: q and the flags go to 0 immediately. Counting resumes on the first edge after deassert with inc high. From q = 0 that edge first clamps to lo_lim if lo_lim > 0.

## Test plan
- Reset, then WIDTH=16, lo=0, hi=9, step=1, up, inc 12 cycles -> q 1..9, 0, 1, 2; wrap high only in the cycle q=0; ovf_sticky=1.
- SATURATE=1, lo=0, hi=9, q=8, step=3, up, inc 2 cycles -> q 9, 9; wrap never high; ovf_sticky=1; at_max=1. Then ovf_clr -> ovf_sticky=0.
- Down across zero, SATURATE=0, lo=0, hi=0xFFFF, q=1, step=2 -> q=0xFFFF, wrap pulses. Checks borrow handling at full width.
- Priority: clr, ld (ld_val=5) and inc all high with lo=3 -> q=3. Then ld, ld_val=20, hi=15 -> q=15, no wrap, ovf unchanged.
- lo=10, hi=4 -> cfg_err=1. inc for 5 cycles -> q holds. Then step=0 with valid limits -> q holds, no pulse.
- Reset asserted mid-run at q=7 -> q=0 before the next edge. Deassert with lo=2, inc up -> q=2, then 3.

Source files
------------

// File: rtl/updown_counter_param.sv
// Parametrised up/down event counter with programmable step and limits.
// Wraps to the opposite limit or clips at the limit, depending on SATURATE.
module updown_counter_param #(
    parameter int WIDTH    = 16,
    parameter int STEP_W   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              ld,
    input  logic [WIDTH-1:0]  ld_val,
    input  logic              inc,
    input  logic              uphdnl,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lo_lim,
    input  logic [WIDTH-1:0]  hi_lim,
    input  logic              ovf_clr,
    output logic [WIDTH-1:0]  q,
    output logic              wrap,
    output logic              ovf_sticky,
    output logic              at_max,
    output logic              at_min,
    output logic              cfg_err
);

    // Two spare bits: one carry for the up sum, one sign for the down difference.
    localparam int MW = (WIDTH > STEP_W) ? WIDTH : STEP_W;
    localparam int EW = MW + 2;

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_ovf;

    logic [WIDTH-1:0] w_q_nxt;
    logic             w_wrap_nxt;
    logic             w_clip;
    logic             w_ovf_nxt;

    logic [EW-1:0]    w_q_x;
    logic [EW-1:0]    w_step_x;
    logic [EW-1:0]    w_lo_x;
    logic [EW-1:0]    w_hi_x;
    logic [EW-1:0]    w_sum;
    logic [EW-1:0]    w_dif;
    logic             w_up_ok;
    logic             w_dn_ok;
    logic             w_above;
    logic             w_below;
    logic             w_count;
    logic [WIDTH-1:0] w_ld_clamp;

    assign w_q_x    = {{(EW-WIDTH){1'b0}}, r_q};
    assign w_step_x = {{(EW-STEP_W){1'b0}}, step};
    assign w_lo_x   = {{(EW-WIDTH){1'b0}}, lo_lim};
    assign w_hi_x   = {{(EW-WIDTH){1'b0}}, hi_lim};

    assign w_sum    = w_q_x + w_step_x;
    assign w_dif    = w_q_x - w_step_x;
    assign w_up_ok  = (w_sum <= w_hi_x);
    assign w_dn_ok  = !w_dif[EW-1] && (w_dif >= w_lo_x);

    assign cfg_err  = (lo_lim > hi_lim);
    assign w_above  = (r_q > hi_lim);
    assign w_below  = (r_q < lo_lim);
    assign w_count  = inc && !cfg_err && (step != '0);

    always_comb begin
        w_ld_clamp = ld_val;
        if (ld_val < lo_lim) begin
            w_ld_clamp = lo_lim;
        end else if (ld_val > hi_lim) begin
            w_ld_clamp = hi_lim;
        end
    end

    always_comb begin
        w_q_nxt    = r_q;
        w_wrap_nxt = 1'b0;
        w_clip     = 1'b0;
        if (clr) begin
            w_q_nxt = lo_lim;
        end else if (ld) begin
            w_q_nxt = w_ld_clamp;
        end else if (w_count) begin
            // An out-of-range count is pulled back silently before counting resumes.
            if (w_above) begin
                w_q_nxt = hi_lim;
            end else if (w_below) begin
                w_q_nxt = lo_lim;
            end else if (uphdnl) begin
                if (w_up_ok) begin
                    w_q_nxt = w_sum[WIDTH-1:0];
                end else if (SATURATE) begin
                    w_q_nxt = hi_lim;
                    w_clip  = 1'b1;
                end else begin
                    w_q_nxt    = lo_lim;
                    w_wrap_nxt = 1'b1;
                end
            end else begin
                if (w_dn_ok) begin
                    w_q_nxt = w_dif[WIDTH-1:0];
                end else if (SATURATE) begin
                    w_q_nxt = lo_lim;
                    w_clip  = 1'b1;
                end else begin
                    w_q_nxt    = hi_lim;
                    w_wrap_nxt = 1'b1;
                end
            end
        end
    end

    // A set in the same cycle as a clear wins.
    assign w_ovf_nxt = w_wrap_nxt || w_clip || (r_ovf && !ovf_clr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_wrap <= w_wrap_nxt;
            r_ovf  <= w_ovf_nxt;
        end
    end

    assign q          = r_q;
    assign wrap       = r_wrap;
    assign ovf_sticky = r_ovf;
    assign at_max     = (r_q == hi_lim);
    assign at_min     = (r_q == lo_lim);

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: a wrap and a saturate instance share stimulus.
// Expected per-edge state is queued when driven and compared after the edge.
module tb_updown_counter_param;

    logic        clk;
    logic        reset;
    logic        clr;
    logic        ld;
    logic [15:0] ld_val;
    logic        inc;
    logic        uphdnl;
    logic [3:0]  step;
    logic [15:0] lo_lim;
    logic [15:0] hi_lim;
    logic        ovf_clr;

    logic [15:0] q_o   [2];
    logic        wr_o  [2];
    logic        ovf_o [2];
    logic        mx_o  [2];
    logic        mn_o  [2];
    logic        ce_o  [2];

    typedef struct {
        int m;
        int q;
        bit w;
        bit o;
    } exp_t;

    exp_t sb[$];
    int   mq [2];
    bit   mo [2];
    int   n_run;
    int   n_fail;

    updown_counter_param #(.WIDTH(16), .STEP_W(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .clr(clr), .ld(ld), .ld_val(ld_val),
        .inc(inc), .uphdnl(uphdnl), .step(step), .lo_lim(lo_lim),
        .hi_lim(hi_lim), .ovf_clr(ovf_clr), .q(q_o[0]), .wrap(wr_o[0]),
        .ovf_sticky(ovf_o[0]), .at_max(mx_o[0]), .at_min(mn_o[0]),
        .cfg_err(ce_o[0])
    );

    updown_counter_param #(.WIDTH(16), .STEP_W(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .clr(clr), .ld(ld), .ld_val(ld_val),
        .inc(inc), .uphdnl(uphdnl), .step(step), .lo_lim(lo_lim),
        .hi_lim(hi_lim), .ovf_clr(ovf_clr), .q(q_o[1]), .wrap(wr_o[1]),
        .ovf_sticky(ovf_o[1]), .at_max(mx_o[1]), .at_min(mn_o[1]),
        .cfg_err(ce_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_expect();
        int lo, hi, lv, st, q, nq, t;
        bit w, clip;
        lo = int'(lo_lim);
        hi = int'(hi_lim);
        lv = int'(ld_val);
        st = int'(step);
        for (int m = 0; m < 2; m++) begin
            q = mq[m];
            nq = q;
            w = 1'b0;
            clip = 1'b0;
            if (clr) begin
                nq = lo;
            end else if (ld) begin
                nq = (lv < lo) ? lo : ((lv > hi) ? hi : lv);
            end else if (inc && lo <= hi && st != 0) begin
                if (q > hi) nq = hi;
                else if (q < lo) nq = lo;
                else begin
                    t = uphdnl ? q + st : q - st;
                    if (t >= lo && t <= hi) nq = t;
                    else if (m == 1) begin
                        nq = uphdnl ? hi : lo;
                        clip = 1'b1;
                    end else begin
                        nq = uphdnl ? lo : hi;
                        w = 1'b1;
                    end
                end
            end
            mq[m] = nq;
            mo[m] = (w || clip) ? 1'b1 : (ovf_clr ? 1'b0 : mo[m]);
            sb.push_back('{m, nq, w, mo[m]});
        end
    endtask

    task automatic check_comb(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk({tag, "_at_max"}, 32'(mx_o[m]), 32'(mq[m] == int'(hi_lim)));
            chk({tag, "_at_min"}, 32'(mn_o[m]), 32'(mq[m] == int'(lo_lim)));
            chk({tag, "_cfg_err"}, 32'(ce_o[m]), 32'(lo_lim > hi_lim));
        end
    endtask

    task automatic cyc(input string tag);
        exp_t e;
        push_expect();
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_q"}, 32'(q_o[e.m]), 32'(e.q));
            chk({tag, "_wrap"}, 32'(wr_o[e.m]), 32'(e.w));
            chk({tag, "_ovf"}, 32'(ovf_o[e.m]), 32'(e.o));
        end
        check_comb(tag);
        @(negedge clk);
    endtask

    task automatic idle();
        clr = 0; ld = 0; inc = 0; ovf_clr = 0;
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        reset = 1'b1;
        idle();
        ld_val = 0; uphdnl = 1; step = 1; lo_lim = 0; hi_lim = 9;
        mq = '{0, 0};
        mo = '{0, 0};
        repeat (2) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk("rst_q", 32'(q_o[m]), 32'h0);
            chk("rst_wrap", 32'(wr_o[m]), 32'h0);
            chk("rst_ovf", 32'(ovf_o[m]), 32'h0);
        end
        check_comb("rst");
        reset = 1'b0;

        inc = 1;
        for (int i = 0; i < 12; i++) cyc("up_wrap");
        chk("up_wrap_final_q", 32'(q_o[0]), 32'd2);
        chk("up_wrap_final_ovf", 32'(ovf_o[0]), 32'd1);
        chk("up_sat_final_q", 32'(q_o[1]), 32'd9);

        idle();
        ld = 1; ld_val = 8; ovf_clr = 1;
        cyc("sat_ld");
        idle();
        inc = 1; step = 3;
        for (int i = 0; i < 2; i++) cyc("sat_up");
        chk("sat_q", 32'(q_o[1]), 32'd9);
        chk("sat_at_max", 32'(mx_o[1]), 32'd1);
        chk("sat_ovf", 32'(ovf_o[1]), 32'd1);
        idle();
        ovf_clr = 1;
        cyc("ovf_clr");
        chk("ovf_clr_sat", 32'(ovf_o[1]), 32'd0);

        idle();
        hi_lim = 16'hFFFF; lo_lim = 0; ld = 1; ld_val = 1;
        cyc("dn_ld");
        idle();
        inc = 1; uphdnl = 0; step = 2;
        cyc("dn_borrow");
        chk("dn_borrow_q", 32'(q_o[0]), 32'hFFFF);
        chk("dn_borrow_wrap", 32'(wr_o[0]), 32'd1);

        lo_lim = 3; hi_lim = 15; clr = 1; ld = 1; ld_val = 5; uphdnl = 1;
        cyc("prio");
        chk("prio_q", 32'(q_o[0]), 32'd3);
        idle();
        ld = 1; ld_val = 20;
        cyc("ld_clamp");
        chk("ld_clamp_q", 32'(q_o[1]), 32'd15);

        idle();
        lo_lim = 10; hi_lim = 4; inc = 1; step = 1;
        #1;
        chk("cfg_err_set", 32'(ce_o[0]), 32'd1);
        for (int i = 0; i < 5; i++) cyc("cfg_hold");
        lo_lim = 0; hi_lim = 20; step = 0;
        for (int i = 0; i < 3; i++) cyc("step0_hold");
        chk("step0_q", 32'(q_o[0]), 32'd15);

        for (int i = 0; i < 400; i++) begin
            if (i % 16 == 0) begin
                lo_lim = 16'($urandom_range(0, 30));
                hi_lim = 16'($urandom_range(0, 40));
            end
            clr = ($urandom_range(0, 19) == 0);
            ld = ($urandom_range(0, 9) == 0);
            ld_val = 16'($urandom_range(0, 50));
            inc = ($urandom_range(0, 3) != 0);
            uphdnl = 1'($urandom_range(0, 1));
            step = 4'($urandom_range(0, 15));
            ovf_clr = ($urandom_range(0, 7) == 0);
            cyc("rand");
        end

        idle();
        lo_lim = 0; hi_lim = 9; step = 1; uphdnl = 1; ld = 1; ld_val = 7;
        cyc("pre_rst");
        chk("pre_rst_q", 32'(q_o[0]), 32'd7);
        idle();
        #2;
        reset = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("mid_rst_q", 32'(q_o[m]), 32'h0);
            chk("mid_rst_wrap", 32'(wr_o[m]), 32'h0);
            chk("mid_rst_ovf", 32'(ovf_o[m]), 32'h0);
        end
        mq = '{0, 0};
        mo = '{0, 0};
        @(negedge clk);
        lo_lim = 2; inc = 1;
        reset = 1'b0;
        cyc("post_rst1");
        chk("post_rst1_q", 32'(q_o[0]), 32'd2);
        cyc("post_rst2");
        chk("post_rst2_q", 32'(q_o[1]), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
